// File: rtl/hpmevent_sel_if.sv
// Bus between the CSR/pipeline side and the performance-counter event selector.
// The selector takes the slave modport; the pipeline and counter bank take the master side.
interface hpmevent_sel_if #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned COUNTERS   = 32,
  parameter int unsigned NUM_EVENTS = 32
);
  logic                  CSRMWriteM;
  logic [11:0]           CSRAdrM;
  logic [XLEN-1:0]       CSRWriteValM;
  logic [1:0]            PrivilegeModeW;
  logic                  InstrValidNotFlushedM;
  logic [NUM_EVENTS-1:0] RawEventM;
  logic [COUNTERS-1:0]   CounterOverflowM;
  logic [COUNTERS-1:0]   CounterEventM;
  logic [XLEN-1:0]       EventReadValM;
  logic                  IllegalEventAccessM;
  logic                  LCOFISetM;

  modport master (
    output CSRMWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeW,
    output InstrValidNotFlushedM, RawEventM, CounterOverflowM,
    input  CounterEventM, EventReadValM, IllegalEventAccessM, LCOFISetM
  );

  modport slave (
    input  CSRMWriteM, CSRAdrM, CSRWriteValM, PrivilegeModeW,
    input  InstrValidNotFlushedM, RawEventM, CounterOverflowM,
    output CounterEventM, EventReadValM, IllegalEventAccessM, LCOFISetM
  );
endinterface

// File: rtl/hpmevent_sel.sv
// mhpmevent3..COUNTERS-1 CSRs: routes selected raw events (with privilege inhibits)
// to the counter bank as registered increment enables, and tracks counter overflow (OF / LCOFI).
module hpmevent_sel #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned COUNTERS   = 32,
  parameter int unsigned NUM_EVENTS = 32,
  parameter int unsigned EVSELW     = 5
) (
  input  logic           clk,
  input  logic           reset,
  hpmevent_sel_if.slave  bus
);

  localparam int unsigned RAWW   = 1 << EVSELW;
  localparam logic [1:0]  PRIV_U = 2'd0;
  localparam logic [1:0]  PRIV_S = 2'd1;
  localparam logic [1:0]  PRIV_M = 2'd3;

  logic [EVSELW-1:0]   r_sel [COUNTERS];
  logic [COUNTERS-1:0] r_uinh;
  logic [COUNTERS-1:0] r_sinh;
  logic [COUNTERS-1:0] r_minh;
  logic [COUNTERS-1:0] r_of;
  logic [COUNTERS-1:0] r_evt;
  logic                r_lcofi;

  logic [4:0]          w_idx;
  logic                w_is_lo;
  logic                w_is_hi;
  logic                w_in_range;
  logic                w_illegal;
  logic                w_wr;
  logic                w_wr_sel;
  logic                w_wr_flags;
  logic [XLEN-1:0]     w_selraw;
  logic [EVSELW-1:0]   w_sel_wr;
  logic [3:0]          w_flags_wr;
  logic [RAWW-1:0]     w_raw;
  logic                w_inh;
  logic                w_hit;
  logic [COUNTERS-1:0] w_evt;
  logic [COUNTERS-1:0] w_of_nxt;
  logic [COUNTERS-1:0] w_new_of;
  logic [XLEN-1:0]     w_rd;

  // Address decode: 0x320..0x33F always, 0x720..0x73F only as the RV32 high half.
  assign w_idx      = bus.CSRAdrM[4:0];
  assign w_is_lo    = (bus.CSRAdrM[11:5] == 7'h19);
  assign w_is_hi    = (XLEN == 32) && (bus.CSRAdrM[11:5] == 7'h39);
  assign w_in_range = ({1'b0, w_idx} < 6'(COUNTERS));
  assign w_illegal  = (bus.PrivilegeModeW != PRIV_M) ||
                      ((w_is_lo || w_is_hi) && !w_in_range);
  assign w_wr       = bus.CSRMWriteM && !w_illegal && (w_is_lo || w_is_hi) &&
                      (w_idx >= 5'd3);
  assign w_wr_sel   = w_wr && w_is_lo;
  assign w_wr_flags = w_wr && ((XLEN == 64) ? w_is_lo : w_is_hi);

  // WARL select: anything beyond the implemented event range collapses to "no event".
  always_comb begin
    w_selraw = bus.CSRWriteValM;
    if (XLEN == 64) w_selraw[XLEN-1 -: 4] = 4'b0000;
    w_sel_wr   = (w_selraw < XLEN'(NUM_EVENTS)) ? w_selraw[EVSELW-1:0] : '0;
    w_flags_wr = bus.CSRWriteValM[XLEN-1 -: 4];
  end

  assign w_raw = RAWW'(bus.RawEventM);

  // Per-counter event qualification; counters 0..2 are fixed-function.
  always_comb begin
    w_evt    = '0;
    w_inh    = 1'b0;
    w_evt[0] = 1'b1;
    w_evt[2] = bus.InstrValidNotFlushedM;
    for (int i = 3; i < COUNTERS; i++) begin
      case (bus.PrivilegeModeW)
        PRIV_M:  w_inh = r_minh[i];
        PRIV_S:  w_inh = r_sinh[i];
        PRIV_U:  w_inh = r_uinh[i];
        default: w_inh = 1'b0;
      endcase
      w_evt[i] = w_raw[r_sel[i]] && (r_sel[i] != '0) && !w_inh;
    end
  end

  // OF update: a write replaces OF but a same-cycle overflow still sets it.
  always_comb begin
    w_of_nxt = r_of;
    w_new_of = '0;
    w_hit    = 1'b0;
    for (int i = 3; i < COUNTERS; i++) begin
      w_hit = w_wr_flags && (w_idx == 5'(i));
      if (w_hit) w_of_nxt[i] = w_flags_wr[3] | bus.CounterOverflowM[i];
      else       w_of_nxt[i] = r_of[i] | bus.CounterOverflowM[i];
      w_new_of[i] = bus.CounterOverflowM[i] && !r_of[i] && !(w_hit && w_flags_wr[3]);
    end
  end

  // CSR read mux.
  always_comb begin
    w_rd = '0;
    for (int i = 3; i < COUNTERS; i++) begin
      if (w_idx == 5'(i)) begin
        if (w_is_lo) begin
          w_rd[EVSELW-1:0] = r_sel[i];
          if (XLEN == 64) w_rd[XLEN-1 -: 4] = {r_of[i], r_minh[i], r_sinh[i], r_uinh[i]};
        end
        if (w_is_hi) w_rd[XLEN-1 -: 4] = {r_of[i], r_minh[i], r_sinh[i], r_uinh[i]};
      end
    end
    if (w_illegal) w_rd = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COUNTERS; i++) r_sel[i] <= '0;
      r_uinh  <= '0;
      r_sinh  <= '0;
      r_minh  <= '0;
      r_of    <= '0;
      r_evt   <= '0;
      r_lcofi <= 1'b0;
    end else begin
      r_evt   <= w_evt;
      r_lcofi <= |w_new_of;
      r_of    <= w_of_nxt;
      for (int i = 3; i < COUNTERS; i++) begin
        if (w_wr_sel && (w_idx == 5'(i))) r_sel[i] <= w_sel_wr;
        if (w_wr_flags && (w_idx == 5'(i))) begin
          r_minh[i] <= w_flags_wr[2];
          r_sinh[i] <= w_flags_wr[1];
          r_uinh[i] <= w_flags_wr[0];
        end
      end
    end
  end

  assign bus.CounterEventM       = r_evt;
  assign bus.LCOFISetM           = r_lcofi;
  assign bus.EventReadValM       = w_rd;
  assign bus.IllegalEventAccessM = w_illegal;

endmodule
